// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the protocol FSMs, the node memory and the port arbiter.
// The arbiter connects through the slave modport; the requester/memory side
// (or a testbench standing in for it) uses the master modport.
interface mem_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int WORD_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_wr_en;
    logic [NUM_REQ*WORD_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [WORD_WIDTH-1:0]         req_rdata;
    logic [NUM_REQ-1:0]            req_rvalid;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic                          mem_wr_en;
    logic [WORD_WIDTH-1:0]         mem_data_in;
    logic [WORD_WIDTH-1:0]         mem_data_out;
    logic                          busy;
    logic                          err_addr;
    logic                          err_hold;

    modport slave (
        input  req, req_addr, req_wr_en, req_wdata, mem_data_out,
        output gnt, req_rdata, req_rvalid, mem_addr, mem_wr_en, mem_data_in,
               busy, err_addr, err_hold
    );

    modport master (
        output req, req_addr, req_wr_en, req_wdata, mem_data_out,
        input  gnt, req_rdata, req_rvalid, mem_addr, mem_wr_en, mem_data_in,
               busy, err_addr, err_hold
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-port node memory between protocol FSMs.
// An owner keeps the port for as long as it holds req, so a read-modify-write
// sequence is never interleaved with another requester.
//
//  state | meaning
//  IDLE  | no owner, gnt=0; picks the next requester at or above ptr
//  BUSY  | one owner granted; released one edge after its req drops
module mem_port_arbiter #(
    parameter int                    NUM_REQ    = 4,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    WORD_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] MEM_TOP    = 'h70D,
    parameter int                    MAX_HOLD   = 64
) (
    input  logic                clock,
    input  logic                nrst,
    mem_port_arbiter_if.slave   bus
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        ptr, ptr_nxt;
    logic [PW-1:0]        owner, owner_nxt;
    logic [NUM_REQ-1:0]   gnt_q, gnt_nxt;
    logic [HW-1:0]        hold_cnt, hold_nxt;
    logic [NUM_REQ-1:0]   rvalid_q;
    logic                 err_addr_q;

    logic                 found;
    logic [PW-1:0]        pick;
    int                   idx;

    logic                 owned;
    logic [ADDR_WIDTH-1:0] owner_addr;
    logic [WORD_WIDTH-1:0] owner_wdata;
    logic                 addr_ok;
    logic                 wr_en;

    // Round-robin search: first set req at or above ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Owner datapath mux; writes beyond the address map are never issued
    always_comb begin
        owned       = |gnt_q;
        owner_addr  = bus.req_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
        owner_wdata = bus.req_wdata[int'(owner)*WORD_WIDTH +: WORD_WIDTH];
        addr_ok     = (owner_addr <= MEM_TOP);
        wr_en       = owned & bus.req_wr_en[owner] & addr_ok;
    end

    assign bus.mem_addr    = owned ? owner_addr  : '0;
    assign bus.mem_data_in = owned ? owner_wdata : '0;
    assign bus.mem_wr_en   = wr_en;
    assign bus.gnt         = gnt_q;
    assign bus.req_rdata   = bus.mem_data_out;
    assign bus.req_rvalid  = rvalid_q;
    assign bus.busy        = (state == BUSY);
    assign bus.err_addr    = err_addr_q;
    // Advisory only: the owner is never preempted
    assign bus.err_hold    = (state == BUSY) && (hold_cnt == HW'(MAX_HOLD))
                             && |(bus.req & ~gnt_q);

    // Next-state and grant decisions
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        gnt_nxt   = gnt_q;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (found) begin
                    state_nxt = BUSY;
                    owner_nxt = pick;
                    gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    hold_nxt  = '0;
                end
            end
            BUSY: begin
                if (bus.req[owner]) begin
                    if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    hold_nxt  = '0;
                    ptr_nxt   = (owner == PW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // State, grant and hold counter registers
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            gnt_q    <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            gnt_q    <= gnt_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Read-valid pulse and sticky address-map error
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            rvalid_q   <= '0;
            err_addr_q <= 1'b0;
        end else begin
            rvalid_q   <= gnt_q & {NUM_REQ{~wr_en}};
            err_addr_q <= err_addr_q | (owned & ~addr_ok);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences, then random traffic compared against a behavioural model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 11;
    localparam int WW = 16;
    localparam int MAXH = 64;
    localparam logic [AW-1:0] TOP = 11'h70D;

    logic clock = 1'b0;
    logic nrst  = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    mem_port_arbiter dut (
        .clock (clock),
        .nrst  (nrst),
        .bus   (bus)
    );

    // Node memory: write on edge, registered read one cycle after address
    logic [WW-1:0] mem [0:2047];
    int wr_cnt = 0;
    always @(posedge clock) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_data_in;
            wr_cnt++;
        end
        bus.mem_data_out <= mem[bus.mem_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [WW-1:0] d);
        bus.req[i]             = r;
        bus.req_wr_en[i]       = w;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_wdata[i*WW +: WW] = d;
    endtask

    task automatic clear_inputs();
        bus.req       = '0;
        bus.req_wr_en = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    // Ends on a negedge with nrst released
    task automatic do_reset();
        @(negedge clock);
        nrst = 1'b0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        nrst = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  exp_gnt;
        logic [N-1:0]  exp_rvalid;
        logic          exp_busy;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t tbl [16];

    // Behavioural model state
    int            m_owner;
    int            m_ptr;
    int            m_hold;
    bit            m_err;
    logic [N-1:0]  m_rv;

    initial begin
        logic [N-1:0]  e_gnt;
        logic [AW-1:0] e_addr;
        logic [WW-1:0] e_data;
        logic          e_wr;
        logic          e_hold;
        logic [AW-1:0] oa;
        int            wr_before;

        foreach (mem[i]) mem[i] = '0;
        bus.mem_data_out = '0;
        clear_inputs();

        // Contention 1011 from ptr 0 (3-cycle holds), then a 1-cycle pulse
        tbl[0]  = '{4'b1011, 4'b0000, 4'b0000, 1'b0, 11'h000};
        tbl[1]  = '{4'b1011, 4'b0001, 4'b0000, 1'b1, 11'h688};
        tbl[2]  = '{4'b1011, 4'b0001, 4'b0001, 1'b1, 11'h688};
        tbl[3]  = '{4'b1010, 4'b0001, 4'b0001, 1'b1, 11'h688};
        tbl[4]  = '{4'b1010, 4'b0000, 4'b0001, 1'b0, 11'h000};
        tbl[5]  = '{4'b1010, 4'b0010, 4'b0000, 1'b1, 11'h100};
        tbl[6]  = '{4'b1010, 4'b0010, 4'b0010, 1'b1, 11'h100};
        tbl[7]  = '{4'b1000, 4'b0010, 4'b0010, 1'b1, 11'h100};
        tbl[8]  = '{4'b1000, 4'b0000, 4'b0010, 1'b0, 11'h000};
        tbl[9]  = '{4'b1000, 4'b1000, 4'b0000, 1'b1, 11'h200};
        tbl[10] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 11'h200};
        tbl[11] = '{4'b0000, 4'b1000, 4'b1000, 1'b1, 11'h200};
        tbl[12] = '{4'b0000, 4'b0000, 4'b1000, 1'b0, 11'h000};
        tbl[13] = '{4'b0011, 4'b0000, 4'b0000, 1'b0, 11'h000};
        tbl[14] = '{4'b0000, 4'b0001, 4'b0000, 1'b1, 11'h688};
        tbl[15] = '{4'b0000, 4'b0000, 4'b0001, 1'b0, 11'h000};

        // Reset state
        #2;
        check("rst_gnt",      32'(bus.gnt),        32'h0);
        check("rst_busy",     32'(bus.busy),       32'h0);
        check("rst_rvalid",   32'(bus.req_rvalid), 32'h0);
        check("rst_err_addr", 32'(bus.err_addr),   32'h0);
        check("rst_err_hold", 32'(bus.err_hold),   32'h0);
        check("rst_wr_en",    32'(bus.mem_wr_en),  32'h0);

        // Vector table
        mem[11'h688] = 16'h5A5A;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_req(0, tbl[i].req[0], 1'b0, 11'h688, 16'h0);
            set_req(1, tbl[i].req[1], 1'b0, 11'h100, 16'h0);
            set_req(2, tbl[i].req[2], 1'b0, 11'h68A, 16'h0);
            set_req(3, tbl[i].req[3], 1'b0, 11'h200, 16'h0);
            #1;
            check($sformatf("tbl%0d_gnt", i),    32'(bus.gnt),        32'(tbl[i].exp_gnt));
            check($sformatf("tbl%0d_rvalid", i), 32'(bus.req_rvalid), 32'(tbl[i].exp_rvalid));
            check($sformatf("tbl%0d_busy", i),   32'(bus.busy),       32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_addr", i),   32'(bus.mem_addr),   32'(tbl[i].exp_addr));
            check($sformatf("tbl%0d_wr", i),     32'(bus.mem_wr_en),  32'h0);
            if (tbl[i].exp_rvalid[0]) check($sformatf("tbl%0d_rdata", i), 32'(bus.req_rdata), 32'h5A5A);
            @(negedge clock);
        end

        // Read-modify-write by owner 2
        clear_inputs();
        mem[11'h68A] = 16'h1234;
        set_req(2, 1'b1, 1'b0, 11'h68A, 16'h0);
        #1;
        @(negedge clock);
        #1;
        check("rmw_gnt",  32'(bus.gnt),       32'b0100);
        check("rmw_addr", 32'(bus.mem_addr),  32'h68A);
        check("rmw_rd",   32'(bus.mem_wr_en), 32'h0);
        @(negedge clock);
        #1;
        check("rmw_rvalid", 32'(bus.req_rvalid), 32'b0100);
        check("rmw_rdata",  32'(bus.req_rdata),  32'h1234);
        wr_before = wr_cnt;
        set_req(2, 1'b1, 1'b1, 11'h68A, bus.req_rdata + 16'd1);
        #1;
        check("rmw_wr", 32'(bus.mem_wr_en), 32'h1);
        @(negedge clock);
        set_req(2, 1'b0, 1'b0, 11'h68A, 16'h0);
        #1;
        check("rmw_wr_off",    32'(bus.mem_wr_en),  32'h0);
        check("rmw_no_rvalid", 32'(bus.req_rvalid), 32'h0);
        @(negedge clock);
        check("rmw_mem",    32'(mem[11'h68A]),       32'h1235);
        check("rmw_wr_cnt", 32'(wr_cnt - wr_before), 32'h1);

        // Out-of-range write
        set_req(0, 1'b1, 1'b1, 11'h70E, 16'hBEEF);
        #1;
        check("rng_gnt0", 32'(bus.gnt), 32'h0);
        @(negedge clock);
        #1;
        check("rng_gnt",      32'(bus.gnt),       32'b0001);
        check("rng_wr",       32'(bus.mem_wr_en), 32'h0);
        check("rng_addr",     32'(bus.mem_addr),  32'h70E);
        check("rng_err_pre",  32'(bus.err_addr),  32'h0);
        @(negedge clock);
        #1;
        check("rng_err_set", 32'(bus.err_addr), 32'h1);
        clear_inputs();
        repeat (3) @(negedge clock);
        check("rng_err_sticky", 32'(bus.err_addr),   32'h1);
        check("rng_mem",        32'(mem[11'h70E]),   32'h0);
        do_reset();
        #1;
        check("rng_err_clr", 32'(bus.err_addr), 32'h0);

        // Hold limit: owner 1 for 70 cycles while req 0 waits
        set_req(1, 1'b1, 1'b0, 11'h010, 16'h0);
        #1;
        check("hold_idle", 32'(bus.gnt), 32'h0);
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 11'h020, 16'h0);
        for (int k = 0; k < 70; k++) begin
            #1;
            check($sformatf("hold%0d_gnt", k), 32'(bus.gnt),      32'b0010);
            check($sformatf("hold%0d_err", k), 32'(bus.err_hold), 32'(k >= MAXH));
            @(negedge clock);
        end
        set_req(1, 1'b0, 1'b0, 11'h010, 16'h0);
        #1;
        check("hold_rel_gnt", 32'(bus.gnt),      32'b0010);
        check("hold_rel_err", 32'(bus.err_hold), 32'h1);
        @(negedge clock);
        #1;
        check("hold_dead_gnt", 32'(bus.gnt),      32'h0);
        check("hold_dead_err", 32'(bus.err_hold), 32'h0);
        @(negedge clock);
        #1;
        check("hold_next_gnt", 32'(bus.gnt), 32'b0001);
        do_reset();

        // Reset during a write by owner 3
        set_req(3, 1'b1, 1'b1, 11'h300, 16'hAAAA);
        @(negedge clock);
        #1;
        check("rmid_gnt", 32'(bus.gnt),       32'b1000);
        check("rmid_wr",  32'(bus.mem_wr_en), 32'h1);
        wr_before = wr_cnt;
        nrst = 1'b0;
        #1;
        check("rmid_gnt_rst",  32'(bus.gnt),       32'h0);
        check("rmid_wr_rst",   32'(bus.mem_wr_en), 32'h0);
        check("rmid_busy_rst", 32'(bus.busy),      32'h0);
        @(negedge clock);
        check("rmid_mem",    32'(mem[11'h300]),       32'h0);
        check("rmid_wr_cnt", 32'(wr_cnt - wr_before), 32'h0);
        clear_inputs();
        nrst = 1'b1;
        #1;
        check("rmid_idle", 32'(bus.busy), 32'h0);
        @(negedge clock);
        #1;
        check("rmid_gnt_after", 32'(bus.gnt), 32'h0);

        // Random traffic against the behavioural model
        do_reset();
        m_owner = -1; m_ptr = 0; m_hold = 0; m_err = 0; m_rv = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc == 1000) begin
                do_reset();
                m_owner = -1; m_ptr = 0; m_hold = 0; m_err = 0; m_rv = '0;
            end
            @(negedge clock);
            for (int i = 0; i < N; i++) begin
                logic r;
                logic [AW-1:0] a;
                r = bus.req[i];
                if ($urandom_range(0, 7) == 0) r = ~r;
                if ($urandom_range(0, 63) == 0) a = AW'($urandom_range(32'h70E, 32'h7FF));
                else                            a = AW'($urandom_range(0, 32'h70D));
                set_req(i, r, 1'($urandom), a, WW'($urandom));
            end
            #1;
            e_gnt  = '0;
            e_addr = '0;
            e_data = '0;
            e_wr   = 1'b0;
            e_hold = 1'b0;
            oa     = '0;
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                oa     = bus.req_addr[m_owner*AW +: AW];
                e_addr = oa;
                e_data = bus.req_wdata[m_owner*WW +: WW];
                e_wr   = bus.req_wr_en[m_owner] && (oa <= TOP);
                e_hold = (m_hold == MAXH) && ((bus.req & ~e_gnt) != 0);
            end
            check("rnd_gnt",      32'(bus.gnt),         32'(e_gnt));
            check("rnd_addr",     32'(bus.mem_addr),    32'(e_addr));
            check("rnd_data",     32'(bus.mem_data_in), 32'(e_data));
            check("rnd_wr",       32'(bus.mem_wr_en),   32'(e_wr));
            check("rnd_rvalid",   32'(bus.req_rvalid),  32'(m_rv));
            check("rnd_busy",     32'(bus.busy),        32'(m_owner >= 0));
            check("rnd_err_addr", 32'(bus.err_addr),    32'(m_err));
            check("rnd_err_hold", 32'(bus.err_hold),    32'(e_hold));
            @(posedge clock);
            m_rv = (m_owner >= 0 && !e_wr) ? e_gnt : '0;
            if (m_owner >= 0 && oa > TOP) m_err = 1'b1;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && bus.req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                        m_hold  = 0;
                    end
                end
            end else if (bus.req[m_owner]) begin
                if (m_hold < MAXH) m_hold++;
            end else begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
